// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: clog2, level width and parameter legality.
// Latency: none (compile-time only).
// Backpressure: not applicable.
`ifndef FIFO_LVL_W
`define FIFO_LVL_W(addr_w) ((addr_w) + 1)
`endif

package fifo_pkg;

    // Ceiling log2, usable in constant expressions. clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Level counters must represent 0..DEPTH inclusive, hence one bit more
    // than the address.
    function automatic int fifo_level_w(input int addr_w);
        return `FIFO_LVL_W(addr_w);
    endfunction

    // Legal parameter set for a power-of-two FIFO with level thresholds.
    function automatic bit fifo_params_ok(
        input int data_w,
        input int addr_w,
        input int afull,
        input int aempty
    );
        int depth;
        if (addr_w < 2 || addr_w > 30) begin
            return 1'b0;
        end
        depth = 1 << addr_w;
        return (data_w >= 1)
            && (clog2(depth) == addr_w)
            && (afull >= 1) && (afull <= depth)
            && (aempty >= 0) && (aempty <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple-dual-port RAM: one write port, one read port with registered address.
// Latency: o_rdata reflects the word at the address captured on the last i_re edge.
// Backpressure: none; holding i_re low keeps the address, so o_rdata stays stable.
//
// Ports:
//   i_clk            clock, rising edge
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr     read address load enable / address
//   o_rdata          data at the registered read address
// No reset: contents and the address register are only meaningful once written.
module fifo_ram_sdp #(
    parameter int DATA = 8,
    parameter int ADDR = 6
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [ADDR-1:0] i_waddr,
    input  logic [DATA-1:0] i_wdata,
    input  logic            i_re,
    input  logic [ADDR-1:0] i_raddr,
    output logic [DATA-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR;

    logic [DATA-1:0] r_mem [0:DEPTH-1];
    logic [ADDR-1:0] r_raddr;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered address, array output: the block-RAM read style the
    // synthesis tools map without extra logic.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_raddr <= i_raddr;
        end
    end

    assign o_rdata = r_mem[r_raddr];

endmodule

// File: rtl/fifo_sync_bram.sv
// Synchronous first-word-fall-through FIFO on block RAM with level and almost flags.
// Latency: a word written into an empty FIFO is on out_data two edges after the write.
// Backpressure: in_ready = level < DEPTH (registered); out_data/out_valid hold while !out_ready.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset (released synchronously)
//   flush              synchronous clear, beats any write/read on the same edge
//   in_valid/in_data/in_ready      write side, valid/ready
//   out_valid/out_data/out_ready   read side, valid/ready, out_data registered
//   level              words held 0..DEPTH, including words still in the read pipeline
//   almost_full        level >= AFULL
//   almost_empty       level <= AEMPTY
module fifo_sync_bram
    import fifo_pkg::*;
#(
    parameter int DATA   = 8,
    parameter int ADDR   = 6,
    parameter int AFULL  = (1 << ADDR) - 2,
    parameter int AEMPTY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [DATA-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [DATA-1:0] out_data,
    input  logic            out_ready,
    output logic [ADDR:0]   level,
    output logic            almost_full,
    output logic            almost_empty
);

    localparam int LW = fifo_level_w(ADDR);

    localparam logic [LW-1:0] L_DEPTH  = LW'(1 << ADDR);
    localparam logic [LW-1:0] L_AFULL  = LW'(AFULL);
    localparam logic [LW-1:0] L_AEMPTY = LW'(AEMPTY);

    generate
        if (!fifo_params_ok(DATA, ADDR, AFULL, AEMPTY)) begin : g_bad_params
            $error("fifo_sync_bram: illegal DATA/ADDR/AFULL/AEMPTY combination");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reset: asserts immediately with rst, releases on a clk edge so all
    // state leaves reset in the same cycle.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    // ------------------------------------------------------------------
    // State
    //   r_level     every word accepted and not yet popped
    //   r_q_vld     RAM read-data stage holds a fetched word (address is
    //               held in the RAM, so the word stays put until moved)
    //   r_out_vld   output register holds the oldest word
    // Words sitting in RAM but not yet fetched = level - q_vld - out_vld.
    // ------------------------------------------------------------------
    logic [ADDR-1:0] r_wr_ptr;
    logic [ADDR-1:0] r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_q_vld;
    logic            r_out_vld;
    logic [DATA-1:0] r_out_dat;
    logic            r_in_rdy;
    logic            r_afull;
    logic            r_aempty;

    logic            w_wr;
    logic            w_pop;
    logic            w_xfer;
    logic            w_issue;
    logic [LW-1:0]   w_ram_cnt;
    logic [LW-1:0]   w_level_nxt;
    logic [DATA-1:0] w_ram_rdat;

    assign w_wr  = in_valid  & r_in_rdy  & ~flush;
    assign w_pop = out_ready & r_out_vld & ~flush;

    assign w_ram_cnt = r_level - LW'(r_q_vld) - LW'(r_out_vld);

    // Read stage -> output register whenever the output is free or being popped.
    assign w_xfer = ~flush & r_q_vld & (~r_out_vld | w_pop);

    // Fetch the next RAM word whenever the read stage is free or emptying.
    // Only words written on an earlier edge are counted, so the fetch never
    // depends on a same-edge RAM write.
    assign w_issue = ~flush & (w_ram_cnt != '0) & (~r_q_vld | w_xfer);

    always_comb begin
        w_level_nxt = r_level;
        if (flush) begin
            w_level_nxt = '0;
        end else begin
            w_level_nxt = r_level + LW'(w_wr) - LW'(w_pop);
        end
    end

    fifo_ram_sdp #(
        .DATA (DATA),
        .ADDR (ADDR)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_re    (w_issue),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdat)
    );

    // Pointers wrap naturally at DEPTH; full/empty come from the level only.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_q_vld <= 1'b0;
        end else if (flush) begin
            r_q_vld <= 1'b0;
        end else if (w_issue) begin
            r_q_vld <= 1'b1;
        end else if (w_xfer) begin
            r_q_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
        end else if (flush) begin
            r_out_vld <= 1'b0;
        end else if (w_xfer) begin
            r_out_vld <= 1'b1;
            r_out_dat <= w_ram_rdat;
        end else if (w_pop) begin
            r_out_vld <= 1'b0;
        end
    end

    // Level and all level-derived flags share the next-state value so they
    // always agree within a cycle. in_ready follows the registered level,
    // so a pop at full frees space only from the next cycle.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_level  <= '0;
            r_in_rdy <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_level  <= w_level_nxt;
            r_in_rdy <= (w_level_nxt < L_DEPTH);
            r_afull  <= (w_level_nxt >= L_AFULL);
            r_aempty <= (w_level_nxt <= L_AEMPTY);
        end
    end

    assign in_ready     = r_in_rdy;
    assign out_valid    = r_out_vld;
    assign out_data     = r_out_dat;
    assign level        = r_level;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;

endmodule

// File: tb/tb_fifo_sync_bram.sv
// Self-checking bench for fifo_sync_bram (DATA=8, ADDR=2, AFULL=3, AEMPTY=1).
// Reference: a queue of (write edge, word); the head is visible two edges after its write.
// Directed scenarios followed by randomized traffic with occasional flush.
module tb_fifo_sync_bram;

    localparam int DEPTH = 4;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       flush     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       almost_full;
    logic       almost_empty;

    fifo_sync_bram #(
        .DATA   (8),
        .ADDR   (2),
        .AFULL  (3),
        .AEMPTY (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         w;
        logic [7:0] d;
    } ent_t;

    ent_t mq[$];
    int   edge_n = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Head word visible once two edges have passed since it was written.
    function automatic bit m_valid(input int at);
        return (mq.size() > 0) && (mq[0].w + 2 <= at);
    endfunction

    task automatic check_all(input string tag);
        bit v;
        v = m_valid(edge_n);
        chk({tag, ".in_ready"},  32'(in_ready),     32'(mq.size() < DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid),    32'(v));
        chk({tag, ".level"},     32'(level),        32'(mq.size()));
        chk({tag, ".afull"},     32'(almost_full),  32'(mq.size() >= 3));
        chk({tag, ".aempty"},    32'(almost_empty), 32'(mq.size() <= 1));
        if (v) begin
            chk({tag, ".out_data"}, 32'(out_data), 32'(mq[0].d));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready),     32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid),    32'd0);
        chk({tag, ".out_data"},  32'(out_data),     32'd0);
        chk({tag, ".level"},     32'(level),        32'd0);
        chk({tag, ".afull"},     32'(almost_full),  32'd0);
        chk({tag, ".aempty"},    32'(almost_empty), 32'd1);
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, check.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy,
                        input logic fl, input string tag);
        bit pv;
        bit wr;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        pv = m_valid(edge_n);
        edge_n++;
        if (fl) begin
            mq.delete();
        end else begin
            wr = iv && (mq.size() < DEPTH);
            if (ordy && pv) begin
                void'(mq.pop_front());
            end
            if (wr) begin
                mq.push_back('{edge_n, d});
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, "idle");

        // Two-edge latency, no bypass.
        step(1'b1, 8'hA5, 1'b0, 1'b0, "lat_w");
        step(1'b0, 8'h00, 1'b0, 1'b0, "lat_e1");
        chk("lat_e1_novalid", 32'(out_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, "lat_e2");
        chk("lat_e2_data", 32'(out_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0, "lat_pop");

        // Fill past full, then drain.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        end
        chk("fill_full_level", 32'(level), 32'd4);
        repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");

        // Continuous streaming across several pointer wraps.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, "stream");
        end
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, "stream_drain");

        // Pop at full with a write offered: write blocked this edge.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pf_fill");
        end
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, "pf_settle");
        step(1'b1, 8'h99, 1'b1, 1'b0, "pf_pop");
        chk("pf_level3", 32'(level), 32'd3);
        step(1'b0, 8'h00, 1'b0, 1'b0, "pf_after");

        // Flush at level 3 drops the write on the same edge.
        step(1'b1, 8'h77, 1'b0, 1'b1, "flush");
        chk("flush_level0", 32'(level), 32'd0);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, "post_flush");

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 2) != 0 || i < 100 ? $urandom_range(0, 1) : 0),
                 ($urandom_range(0, 24) == 0), "rand");
        end

        // Asynchronous reset mid-stream at level 2.
        repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0, "ar_drain");
        step(1'b1, 8'h51, 1'b0, 1'b0, "ar_w");
        step(1'b1, 8'h52, 1'b0, 1'b0, "ar_w");
        step(1'b0, 8'h00, 1'b0, 1'b0, "ar_hold");
        chk("ar_level2", 32'(level), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        mq.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, "ar_idle");
        step(1'b1, 8'h3C, 1'b1, 1'b0, "ar_w3c");
        step(1'b0, 8'h00, 1'b0, 1'b0, "ar_rd1");
        step(1'b0, 8'h00, 1'b0, 1'b0, "ar_rd2");
        chk("ar_first_valid", 32'(out_valid), 32'd1);
        chk("ar_first_data",  32'(out_data),  32'h3C);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, "ar_drain2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
